// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the 9-bit core.
// Owns pc and ir, handshakes with a variable-latency data memory, flags halt and memory timeout.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | ir <- imem_data
// DECODE | halt detection
// EXEC   | ALU cycle; memory ops branch to MEM
// MEM    | dmem request outstanding, bounded by the timeout timer
// WB     | register write, pc update, retire
// HALT   | program finished; start restarts at pc 0
// ERR    | data memory timed out; only reset exits
module cpu_sequencer #(
    parameter int         PC_W        = 10,
    parameter logic [8:0] HALT_CODE   = 9'h1FF,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      imem_data,
    input  logic            dec_branch,
    input  logic            dec_write_reg,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    output logic            alu_en,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            reg_we,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [15:0]      count_inc;
    logic [PC_W-1:0]  pc_inc;

    assign count_inc = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
    assign pc_inc    = pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_DECODE;
            S_DECODE:       state_nxt = (ir == HALT_CODE) ? S_HALT : S_EXEC;
            S_EXEC:         state_nxt = (dec_mem_read | dec_mem_write) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)          state_nxt = dec_mem_read ? S_WB : S_FETCH;
                else if (tmo_cnt == '0) state_nxt = S_ERR;
            end
            S_WB:           state_nxt = S_FETCH;
            S_ERR:          state_nxt = S_ERR;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_FETCH, S_DECODE: busy = 1'b1;
            S_EXEC: begin
                busy   = 1'b1;
                alu_en = 1'b1;
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
            end
            S_WB: begin
                busy   = 1'b1;
                reg_we = dec_write_reg;
            end
            S_HALT: done = 1'b1;
            S_ERR: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    // Timeout timer counts down from MEM_TIMEOUT-1; reaching zero without ack is the last allowed cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        instr_count <= '0;
                    end
                end
                S_FETCH: ir <= imem_data;
                S_EXEC:  tmo_cnt <= TMO_LOAD;
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dec_mem_read) begin
                            pc          <= pc_inc;
                            instr_count <= count_inc;
                        end
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_WB: begin
                    pc          <= (dec_branch & branch_taken) ? branch_target : pc_inc;
                    instr_count <= count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: a default instance plus a PC_W=4 instance for wrap.
module tb_cpu_sequencer;

    localparam logic [8:0] OP_ALU   = 9'h001;
    localparam logic [8:0] OP_LOAD  = 9'h040;
    localparam logic [8:0] OP_STORE = 9'h080;
    localparam logic [8:0] OP_BR    = 9'h0C0;
    localparam logic [8:0] OP_HALT  = 9'h1FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, branch_taken, dmem_ack;
    logic [9:0] branch_target;
    logic [8:0] imem_data;
    logic       dec_branch, dec_write_reg, dec_mem_read, dec_mem_write;
    logic [9:0] pc;
    logic [8:0] ir;
    logic       alu_en, dmem_req, dmem_we, reg_we, busy, done, error;
    logic [15:0] instr_count;

    logic [8:0] prog [0:1023];
    logic [2:0] op;

    assign imem_data     = prog[pc];
    assign op            = ir[8:6];
    assign dec_write_reg = (op == 3'd0) || (op == 3'd1);
    assign dec_mem_read  = (op == 3'd1);
    assign dec_mem_write = (op == 3'd2);
    assign dec_branch    = (op == 3'd3);

    cpu_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .imem_data(imem_data),
        .dec_branch(dec_branch), .dec_write_reg(dec_write_reg),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .branch_taken(branch_taken), .branch_target(branch_target), .dmem_ack(dmem_ack),
        .pc(pc), .ir(ir), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .busy(busy), .done(done), .error(error), .instr_count(instr_count)
    );

    // Narrow instance: every instruction is a plain ALU op, no halt.
    logic        start2;
    logic [3:0]  pc2;
    logic [8:0]  ir2;
    logic        alu_en2, dmem_req2, dmem_we2, reg_we2, busy2, done2, error2;
    logic [15:0] count2;

    cpu_sequencer #(.PC_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start2), .imem_data(OP_ALU),
        .dec_branch(1'b0), .dec_write_reg(1'b1), .dec_mem_read(1'b0), .dec_mem_write(1'b0),
        .branch_taken(1'b0), .branch_target(4'h0), .dmem_ack(1'b0),
        .pc(pc2), .ir(ir2), .alu_en(alu_en2), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
        .reg_we(reg_we2), .busy(busy2), .done(done2), .error(error2), .instr_count(count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = OP_HALT;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        dmem_ack = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({alu_en, dmem_req, dmem_we, reg_we, busy, done, error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {alu_en, dmem_req, dmem_we, reg_we, busy, done, error});
        end
        checks++;
        if (pc !== 10'd0 || ir !== 9'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs: pc %0d ir %h cnt %0d want 0 0 0", pc, ir, instr_count);
        end
    endtask

    task automatic test_alu_halt();
        do_reset();
        clear_prog();
        prog[0] = OP_ALU;
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            checks++;
            if (reg_we !== (k == 4)) begin
                errors++;
                $display("FAIL alu_reg_we cycle %0d: got %b want %b", k, reg_we, (k == 4));
            end
            checks++;
            if (done !== (k == 7)) begin
                errors++;
                $display("FAIL alu_done cycle %0d: got %b want %b", k, done, (k == 7));
            end
            checks++;
            if (alu_en !== (k == 3)) begin
                errors++;
                $display("FAIL alu_en cycle %0d: got %b want %b", k, alu_en, (k == 3));
            end
        end
        checks++;
        if (instr_count !== 16'd1 || pc !== 10'd1) begin
            errors++;
            $display("FAIL alu_retire: cnt %0d pc %0d want 1 1", instr_count, pc);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pc !== 10'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_restart: busy %b pc %0d cnt %0d want 1 0 0", busy, pc, instr_count);
        end
    endtask

    task automatic test_load_wait();
        int mc, rw, rw_cycle;
        mc = 0; rw = 0; rw_cycle = 0;
        do_reset();
        clear_prog();
        prog[0] = OP_LOAD;
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) step();
            if (dmem_req) mc++;
            dmem_ack = dmem_req && (mc == 4);
            if (reg_we) begin
                rw++;
                rw_cycle = k;
            end
        end
        dmem_ack = 1'b0;
        checks++;
        if (mc !== 4) begin
            errors++;
            $display("FAIL load_req_cycles: got %0d want 4", mc);
        end
        checks++;
        if (rw !== 1 || rw_cycle !== 8) begin
            errors++;
            $display("FAIL load_reg_we: count %0d at cycle %0d want 1 at 8", rw, rw_cycle);
        end
        checks++;
        if (pc !== 10'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL load_final: pc %0d done %b want 1 1", pc, done);
        end
    endtask

    task automatic test_store();
        int rq, we, rw;
        rq = 0; we = 0; rw = 0;
        do_reset();
        clear_prog();
        prog[0] = OP_STORE;
        dmem_ack = 1'b1;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (dmem_req) rq++;
            if (dmem_we) we++;
            if (reg_we) rw++;
            if (k == 5) begin
                checks++;
                if (pc !== 10'd1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL store_next_fetch: pc %0d busy %b want 1 1", pc, busy);
                end
            end
        end
        dmem_ack = 1'b0;
        checks++;
        if (rq !== 1 || we !== 1 || rw !== 0) begin
            errors++;
            $display("FAIL store_strobes: req %0d we %0d reg_we %0d want 1 1 0", rq, we, rw);
        end
        checks++;
        if (instr_count !== 16'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL store_retire: cnt %0d done %b want 1 1", instr_count, done);
        end
    endtask

    task automatic test_branch(input logic taken, input logic [9:0] want_pc);
        do_reset();
        clear_prog();
        for (int i = 0; i < 5; i++) prog[i] = OP_ALU;
        prog[5] = OP_BR;
        branch_target = 10'd2;
        branch_taken = taken;
        pulse_start();
        for (int k = 2; k <= 21; k++) step();
        checks++;
        if (pc !== 10'd5) begin
            errors++;
            $display("FAIL branch_reach taken=%b: pc %0d want 5", taken, pc);
        end
        for (int k = 22; k <= 25; k++) step();
        checks++;
        if (pc !== want_pc) begin
            errors++;
            $display("FAIL branch_pc taken=%b: pc %0d want %0d", taken, pc, want_pc);
        end
    endtask

    task automatic test_timeout();
        int mc;
        mc = 0;
        do_reset();
        clear_prog();
        prog[0] = OP_LOAD;
        pulse_start();
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) step();
            if (dmem_req) mc++;
        end
        checks++;
        if (mc !== 16) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d want 16", mc);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || pc !== 10'd0 || ir !== OP_LOAD) begin
            errors++;
            $display("FAIL timeout_err: error %b done %b busy %b pc %0d ir %h want 1 1 0 0 %h",
                     error, done, busy, pc, ir, OP_LOAD);
        end
        pulse_start();
        step();
        step();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_ignores_start: error %b busy %b want 1 0", error, busy);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({alu_en, dmem_req, dmem_we, reg_we, busy, done, error} !== 7'b0 ||
            pc !== 10'd0 || ir !== 9'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL err_reset: outs %b pc %0d ir %h cnt %0d want all 0",
                     {alu_en, dmem_req, dmem_we, reg_we, busy, done, error}, pc, ir, instr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        clear_prog();
        prog[0] = OP_LOAD;
        pulse_start();
        for (int k = 2; k <= 5; k++) step();
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL midmem_req: got %b want 1", dmem_req);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midmem_reset: req %b busy %b done %b want 0 0 0", dmem_req, busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midmem_idle_hold: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 2; k <= 61; k++) step();
        checks++;
        if (pc2 !== 4'd15 || count2 !== 16'd15) begin
            errors++;
            $display("FAIL wrap_pre: pc %0d cnt %0d want 15 15", pc2, count2);
        end
        for (int k = 62; k <= 65; k++) step();
        checks++;
        if (pc2 !== 4'd0 || count2 !== 16'd16 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_post: pc %0d cnt %0d busy %b want 0 16 1", pc2, count2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_alu_halt();
        test_load_wait();
        test_store();
        test_branch(1'b1, 10'd2);
        test_branch(1'b0, 10'd6);
        test_timeout();
        test_reset_mid_mem();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
